// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receive path: FSM states,
// status-register bit positions and the layout of one receive-FIFO entry.
package uart_rx_pkg;

    // Receiver frame-recovery states
    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_DATA      = 3'd2,
        S_PARITY    = 3'd3,
        S_STOP      = 3'd4,
        S_WAIT_IDLE = 3'd5
    } rx_state_e;

    // Bit positions inside RX_status_register (bit 0 is reserved, reads 0)
    localparam int ST_RNR   = 7;
    localparam int ST_OVF   = 6;
    localparam int ST_STOP  = 5;
    localparam int ST_BRK   = 4;
    localparam int ST_PAR   = 3;
    localparam int ST_EMPTY = 2;
    localparam int ST_FULL  = 1;

    // Width of the data field for the standard 8-bit frame
    localparam int RX_DATA_W = 8;

    // One FIFO entry; the top packs entries in exactly this order
    // ({stp_err, par_err, data}) as a flat DATA_SIZE+2 vector.
    typedef struct packed {
        logic                 stp_err;
        logic                 par_err;
        logic [RX_DATA_W-1:0] data;
    } rx_entry_t;

endpackage : uart_rx_pkg

// File: rtl/uart_rx_fifo.sv
// Synchronous receive FIFO. Pointers carry one extra wrap bit so full and
// empty are distinguished without a separate counter. The read port is
// registered: rd_data holds the most recently popped entry.
module uart_rx_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] rd_data_q, rd_data_d;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    // A push into a full FIFO still lands when a pop frees the slot this cycle
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rd_data = rd_data_q;

    // Next pointer and read-register values
    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        rd_data_d = rd_data_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d  = rd_ptr_q + 1'b1;
            rd_data_d = mem[rd_ptr_q[AW-1:0]];
        end
    end

    // Storage array; written only, no reset so it maps onto RAM
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_q[AW-1:0]] <= wr_data;
        end
    end

    // Pointer and read-data registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            rd_data_q <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            rd_data_q <= rd_data_d;
        end
    end

endmodule : uart_rx_fifo

// File: rtl/uart_receiver.sv
// 16x-oversampling UART receiver: input synchronizer, sample-tick
// generator, frame-recovery FSM, receive FIFO and RX status register.
module uart_receiver
    import uart_rx_pkg::*;
#(
    parameter int DATA_SIZE = 8,
    parameter int SIZE_FIFO = 8,
    parameter int SYS_FREQ  = 100000000,
    parameter int BAUD_RATE = 9600,
    parameter int SAMPLE    = 16,
    parameter int BAUD_DVSR = SYS_FREQ / (SAMPLE * BAUD_RATE),
    parameter bit PARITY_EN = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 serial_data_in,
    input  logic                 read_data,
    output logic [DATA_SIZE-1:0] bus_data_out,
    output logic [7:0]           RX_status_register
);

    localparam int TW = (BAUD_DVSR > 1) ? $clog2(BAUD_DVSR) : 1;
    localparam int SW = $clog2(SAMPLE);
    localparam int BW = $clog2(DATA_SIZE + 1);
    localparam int EW = DATA_SIZE + 2;

    logic [1:0]           sync_q, sync_d;
    logic                 rx;
    logic [TW-1:0]        tick_cnt_q, tick_cnt_d;
    logic                 tick;
    rx_state_e            state_q, state_d;
    logic [SW-1:0]        s_cnt_q, s_cnt_d;
    logic [BW-1:0]        b_cnt_q, b_cnt_d;
    logic [DATA_SIZE-1:0] shift_q, shift_d;
    logic                 par_bit_q, par_bit_d;
    logic                 par_err_q, par_err_d;
    logic                 rnr_q, rnr_d;
    logic                 ovf_q, ovf_d;
    logic                 brk_q, brk_d;
    logic                 push;
    logic                 brk_set;
    logic                 mid_bit;
    logic [EW-1:0]        push_entry;
    logic [EW-1:0]        pop_entry;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 pop;

    assign rx      = sync_q[1];
    assign tick    = (tick_cnt_q == TW'(BAUD_DVSR - 1));
    assign mid_bit = tick && (s_cnt_q == SW'(SAMPLE - 1));
    assign pop     = read_data && !fifo_empty;
    // Entry layout matches rx_entry_t: {stp_err, par_err, data}
    assign push_entry = {~rx, par_err_q, shift_q};

    // Synchronizer shift and free-running sample-tick divider
    always_comb begin
        sync_d     = {sync_q[0], serial_data_in};
        tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
    end

    // Frame-recovery next-state logic and push/break strobes
    always_comb begin
        state_d   = state_q;
        s_cnt_d   = s_cnt_q;
        b_cnt_d   = b_cnt_q;
        shift_d   = shift_q;
        par_bit_d = par_bit_q;
        par_err_d = par_err_q;
        push      = 1'b0;
        brk_set   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!rx) begin
                    state_d   = S_START;
                    s_cnt_d   = '0;
                    par_bit_d = 1'b0;
                    par_err_d = 1'b0;
                end
            end
            S_START: begin
                if (tick) begin
                    if (s_cnt_q == SW'(SAMPLE / 2 - 1)) begin
                        // Still low at mid start bit: a real frame, else a glitch
                        if (!rx) begin
                            state_d = S_DATA;
                            s_cnt_d = '0;
                            b_cnt_d = '0;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        s_cnt_d = s_cnt_q + 1'b1;
                    end
                end
            end
            S_DATA: begin
                if (mid_bit) begin
                    s_cnt_d = '0;
                    shift_d = {rx, shift_q[DATA_SIZE-1:1]};
                    b_cnt_d = b_cnt_q + 1'b1;
                    if (b_cnt_q == BW'(DATA_SIZE - 1)) begin
                        state_d = PARITY_EN ? S_PARITY : S_STOP;
                    end
                end else if (tick) begin
                    s_cnt_d = s_cnt_q + 1'b1;
                end
            end
            S_PARITY: begin
                if (mid_bit) begin
                    s_cnt_d   = '0;
                    par_bit_d = rx;
                    par_err_d = (^shift_q) ^ rx;
                    state_d   = S_STOP;
                end else if (tick) begin
                    s_cnt_d = s_cnt_q + 1'b1;
                end
            end
            S_STOP: begin
                if (mid_bit) begin
                    s_cnt_d = '0;
                    // An all-zero frame including the stop bit is a line break
                    if ((shift_q == '0) && !par_bit_q && !rx) begin
                        brk_set = 1'b1;
                        state_d = S_WAIT_IDLE;
                    end else begin
                        push    = 1'b1;
                        state_d = S_IDLE;
                    end
                end else if (tick) begin
                    s_cnt_d = s_cnt_q + 1'b1;
                end
            end
            S_WAIT_IDLE: begin
                if (rx) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Sticky status flags; a successful pop clears them, a new event wins
    always_comb begin
        rnr_d = rnr_q;
        ovf_d = ovf_q;
        brk_d = brk_q;
        if (read_data && fifo_empty) begin
            rnr_d = 1'b1;
        end else if (pop) begin
            rnr_d = 1'b0;
        end
        if (push && fifo_full && !pop) begin
            ovf_d = 1'b1;
        end else if (pop) begin
            ovf_d = 1'b0;
        end
        if (brk_set) begin
            brk_d = 1'b1;
        end else if (pop) begin
            brk_d = 1'b0;
        end
    end

    // Status register assembly; empty/full follow the FIFO directly
    always_comb begin
        RX_status_register           = '0;
        RX_status_register[ST_RNR]   = rnr_q;
        RX_status_register[ST_OVF]   = ovf_q;
        RX_status_register[ST_STOP]  = pop_entry[EW-1];
        RX_status_register[ST_BRK]   = brk_q;
        RX_status_register[ST_PAR]   = pop_entry[EW-2];
        RX_status_register[ST_EMPTY] = fifo_empty;
        RX_status_register[ST_FULL]  = fifo_full;
    end

    assign bus_data_out = pop_entry[DATA_SIZE-1:0];

    // All receiver state registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q     <= 2'b11;
            tick_cnt_q <= '0;
            state_q    <= S_IDLE;
            s_cnt_q    <= '0;
            b_cnt_q    <= '0;
            shift_q    <= '0;
            par_bit_q  <= 1'b0;
            par_err_q  <= 1'b0;
            rnr_q      <= 1'b0;
            ovf_q      <= 1'b0;
            brk_q      <= 1'b0;
        end else begin
            sync_q     <= sync_d;
            tick_cnt_q <= tick_cnt_d;
            state_q    <= state_d;
            s_cnt_q    <= s_cnt_d;
            b_cnt_q    <= b_cnt_d;
            shift_q    <= shift_d;
            par_bit_q  <= par_bit_d;
            par_err_q  <= par_err_d;
            rnr_q      <= rnr_d;
            ovf_q      <= ovf_d;
            brk_q      <= brk_d;
        end
    end

    uart_rx_fifo #(
        .WIDTH (EW),
        .DEPTH (SIZE_FIFO)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (push),
        .pop     (pop),
        .wr_data (push_entry),
        .rd_data (pop_entry),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

endmodule : uart_receiver

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver. The divider is shortened so one bit
// lasts 64 clk; every expected value below is worked out by hand.
module tb_uart_receiver;

    localparam int DVSR = 4;
    localparam int BIT  = 16 * DVSR;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       serial_data_in = 1'b1;
    logic       read_data = 1'b0;
    logic [7:0] bus_data_out;
    logic [7:0] RX_status_register;

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;
    int start_cyc = 0;
    int fall_cyc  = 0;
    logic prev_empty = 1'b1;

    uart_receiver #(
        .DATA_SIZE (8),
        .SIZE_FIFO (8),
        .SYS_FREQ  (100000000),
        .BAUD_RATE (9600),
        .SAMPLE    (16),
        .BAUD_DVSR (DVSR),
        .PARITY_EN (1'b1)
    ) dut (
        .clk                (clk),
        .reset_n            (reset_n),
        .serial_data_in     (serial_data_in),
        .read_data          (read_data),
        .bus_data_out       (bus_data_out),
        .RX_status_register (RX_status_register)
    );

    always #5 clk = ~clk;

    // Cycle counter and capture of the cycle in which empty falls
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (prev_empty && !RX_status_register[2]) fall_cyc = cyc;
        prev_empty = RX_status_register[2];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, obs);
        end
    endtask

    // One frame: start, 8 data LSB first, parity bit, stop bit, then idle
    task automatic send_frame(input logic [7:0] d, input logic par, input logic stp,
                              input int stop_len);
        serial_data_in = 1'b0;
        start_cyc = cyc;
        repeat (BIT) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            serial_data_in = d[i];
            repeat (BIT) @(negedge clk);
        end
        serial_data_in = par;
        repeat (BIT) @(negedge clk);
        serial_data_in = stp;
        repeat (stop_len) @(negedge clk);
        serial_data_in = 1'b1;
        repeat (BIT) @(negedge clk);
    endtask

    task automatic pop_one();
        read_data = 1'b1;
        @(negedge clk);
        read_data = 1'b0;
    endtask

    logic [7:0] ovf_byte;

    initial begin
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk("reset_status", RX_status_register, 8'h04);
        chk("reset_bus", bus_data_out, 8'h00);

        // Good frame 0xA5: four ones, even parity bit 0
        fall_cyc = 0;
        send_frame(8'hA5, 1'b0, 1'b1, BIT);
        chk("a5_not_empty", RX_status_register[2], 1'b0);
        chk("a5_latency_ok", ((fall_cyc - start_cyc) >= 672) && ((fall_cyc - start_cyc) <= 688), 1'b1);
        pop_one();
        chk("a5_bus", bus_data_out, 8'hA5);
        chk("a5_status", RX_status_register, 8'h04);

        // Parity error on 0x3C, then a clean 0x11 clears it
        send_frame(8'h3C, 1'b1, 1'b1, BIT);
        pop_one();
        chk("3c_bus", bus_data_out, 8'h3C);
        chk("3c_status", RX_status_register, 8'h0C);
        send_frame(8'h11, 1'b0, 1'b1, BIT);
        pop_one();
        chk("11_bus", bus_data_out, 8'h11);
        chk("11_status", RX_status_register, 8'h04);

        // Stop error on 0x55; stop low only long enough to cover the sample
        send_frame(8'h55, 1'b0, 1'b0, 48);
        pop_one();
        chk("55_bus", bus_data_out, 8'h55);
        chk("55_status", RX_status_register, 8'h24);

        // Short low glitch on an idle line: nothing pushed
        serial_data_in = 1'b0;
        repeat (12) @(negedge clk);
        serial_data_in = 1'b1;
        repeat (12 * BIT) @(negedge clk);
        chk("glitch_status", RX_status_register, 8'h24);

        // Break: 12 bit times low
        serial_data_in = 1'b0;
        repeat (12 * BIT) @(negedge clk);
        chk("break_status", RX_status_register, 8'h34);
        serial_data_in = 1'b1;
        repeat (2 * BIT) @(negedge clk);
        chk("break_empty", RX_status_register[2], 1'b1);
        send_frame(8'h11, 1'b0, 1'b1, BIT);
        chk("post_break_rx", RX_status_register[2], 1'b0);
        pop_one();
        chk("post_break_bus", bus_data_out, 8'h11);
        chk("post_break_status", RX_status_register, 8'h04);

        // Overflow: nine frames with no reads
        for (int k = 1; k <= 9; k++) begin
            ovf_byte = 8'(k);
            send_frame(ovf_byte, ^ovf_byte, 1'b1, BIT);
            if (k == 8) chk("full_after_8", RX_status_register[1], 1'b1);
        end
        chk("ovf_status", RX_status_register, 8'h42);
        for (int k = 1; k <= 8; k++) begin
            pop_one();
            chk($sformatf("ovf_pop%0d_bus", k), bus_data_out, 32'(k));
            if (k == 1) chk("ovf_first_pop_status", RX_status_register, 8'h00);
        end
        chk("ovf_drained_status", RX_status_register, 8'h04);

        // Read while empty
        pop_one();
        chk("empty_read_status", RX_status_register, 8'h84);
        chk("empty_read_bus_hold", bus_data_out, 8'h08);

        // Reset in the middle of a frame
        serial_data_in = 1'b0;
        repeat (BIT) @(negedge clk);
        serial_data_in = 1'b1;
        repeat (BIT) @(negedge clk);
        serial_data_in = 1'b0;
        repeat (100) @(negedge clk);
        reset_n = 1'b0;
        serial_data_in = 1'b1;
        repeat (3) @(negedge clk);
        chk("midreset_status", RX_status_register, 8'h04);
        chk("midreset_bus", bus_data_out, 8'h00);
        reset_n = 1'b1;
        repeat (2 * BIT) @(negedge clk);
        chk("midreset_empty", RX_status_register, 8'h04);
        send_frame(8'hC3, 1'b0, 1'b1, BIT);
        pop_one();
        chk("c3_bus", bus_data_out, 8'hC3);
        chk("c3_status", RX_status_register, 8'h04);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule : tb_uart_receiver
